pipeline_hazard_controller: RTL
===============================

# pipeline_hazard_controller

Central stall/flush sequencer for the five-stage pipeline. It combines load-use hazard detection, taken-branch squashing and a multi-cycle data-memory wait handshake into one set of per-barrier write/flush enables. It also keeps saturating performance counters and a sticky memory-timeout flag. It sits beside the forwarding units and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB barriers.

## Interface
- MEM_TIMEOUT, 16, consecutive memory-wait cycles (request cycle included) after which memTimeout sets; legal range ≥2
- COUNTER_WIDTH, 32, width of stallCycles and flushCount
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- idLHSRegisterIndex  in  5  rs1 of instruction in ID
- idRHSRegisterIndex  in  5  rs2 of instruction in ID
- idUsesLHS  in  1  ID instruction reads rs1
- idUsesRHS  in  1  ID instruction reads rs2
- exMemRead  in  1  instruction in EX is a load
- exWriteRegisterIndex  in  5  rd of instruction in EX
- exBranchTaken  in  1  branch/jump resolved taken in EX this cycle
- memMemRead  in  1  MEM-stage instruction reads data memory
- memMemWrite  in  1  MEM-stage instruction writes data memory
- memReady  in  1  data memory completes the current access this cycle
- memRequest  out  1  one-cycle start pulse for a new data-memory access
- pcWrite  out  1  PC register load enable
- ifIdWrite  out  1  IF/ID barrier load enable
- ifIdFlush  out  1  IF/ID loads a NOP
- idExWrite  out  1  ID/EX barrier load enable
- idExFlush  out  1  ID/EX loads a bubble (all control bits 0)
- exMemWrite  out  1  EX/MEM barrier load enable
- memWbBubble  out  1  MEM/WB loads a bubble (regWrite=0)
- memTimeout  out  1  sticky: a memory access exceeded MEM_TIMEOUT cycles
- stallCycles  out  COUNTER_WIDTH  saturating count of cycles with pcWrite=0
- flushCount  out  COUNTER_WIDTH  saturating count of branch flushes

## Operation
- State machine with two states, RUN and MEM_WAIT. The registered waitCount spans values 0..MEM_TIMEOUT and saturates.
- memAccess = memMemRead | memMemWrite.
- memStall = memAccess & ~memReady.
- loadUse = exMemRead & (exWriteRegisterIndex≠0) & ((idUsesLHS & idLHSRegisterIndex==exWriteRegisterIndex) | (idUsesRHS & idRHSRegisterIndex==exWriteRegisterIndex)).
- memRequest = memAccess & (state==RUN) & ~reset. It is never asserted in MEM_WAIT.
- Outputs are combinational from state and inputs. Priority is memStall > exBranchTaken > loadUse > normal.
  - memStall: pcWrite=ifIdWrite=idExWrite=exMemWrite=0; flushes 0; memWbBubble=1. A branch or load-use in the same cycle is held, not acted on.
  - exBranchTaken: all enables 1; ifIdFlush=idExFlush=1; memWbBubble=0. loadUse is ignored.
  - loadUse: pcWrite=ifIdWrite=0; idExWrite=1, idExFlush=1; exMemWrite=1; memWbBubble=0.
  - normal: all enables 1, all flushes and bubble 0.
- State transitions:
  - RUN → MEM_WAIT when memStall; waitCount←1.
  - RUN stays RUN otherwise (zero-wait access allowed); waitCount←0.
  - MEM_WAIT → RUN when memReady; waitCount←0.
  - MEM_WAIT stays MEM_WAIT otherwise; waitCount←min(waitCount+1, MEM_TIMEOUT).
- memTimeout←1 when the next waitCount equals MEM_TIMEOUT. It clears only on reset. The stall continues regardless; no forced completion.
- Counters:
  - stallCycles increments each non-reset cycle with pcWrite=0.
  - flushCount increments each non-reset cycle in which the branch-flush branch is taken.
  - Both saturate at all-ones; neither wraps.

## Timing
- Reset (synchronous, sampled at clk edge):
  - Registered effect: state=RUN, waitCount=0, memTimeout=0, counters=0.
  - Combinational outputs while reset is high: pcWrite=ifIdWrite=idExWrite=exMemWrite=0; ifIdFlush=idExFlush=memWbBubble=1; memRequest=0.
- Reset in MEM_WAIT abandons the access. No memRequest is issued while reset is high.
- All hazard responses take effect in the cycle of detection (zero latency). State and counters update at the following edge.
- Load-use inserts exactly one bubble: next cycle the load is in MEM and loadUse deasserts.
- When memReady rises in MEM_WAIT, the stall releases that same cycle (exMemWrite=1). If the next MEM instruction also accesses memory, memRequest pulses the following cycle from RUN.
- Back-to-back zero-wait accesses assert memRequest every cycle.

## Test plan
- Load x5 in EX, ID add uses rs1=x5 → pcWrite=0, ifIdWrite=0, idExFlush=1 for exactly one cycle; stallCycles 0→1.
- Load to x0 in EX, ID reads x0 → no stall; all enables 1.
- exBranchTaken=1 with loadUse also true → ifIdFlush=idExFlush=1, pcWrite=1; flushCount 0→1; stallCycles unchanged.
- memMemRead=1, memReady low 3 cycles then high → memRequest pulses only in cycle 0; all enables 0 and memWbBubble=1 in cycles 0–2; cycle 3 enables 1; state back to RUN; stallCycles=3.
- MEM_TIMEOUT=4, memMemWrite=1, memReady held 0 → memTimeout 0 through cycle 3, 1 from cycle 4; remains 1 after memReady rises; cleared only by reset.
- Reset asserted during MEM_WAIT with memStall and exBranchTaken both high → reset values of all outputs that cycle; next cycle state=RUN, counters 0, memRequest pulses if memAccess is still high.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline hazard inputs, barrier enables, status and counters.
interface pipeline_hazard_controller_if #(
    parameter int COUNTER_WIDTH = 32
);
    logic [4:0]               idLHSRegisterIndex;
    logic [4:0]               idRHSRegisterIndex;
    logic                     idUsesLHS;
    logic                     idUsesRHS;
    logic                     exMemRead;
    logic [4:0]               exWriteRegisterIndex;
    logic                     exBranchTaken;
    logic                     memMemRead;
    logic                     memMemWrite;
    logic                     memReady;
    logic                     memRequest;
    logic                     pcWrite;
    logic                     ifIdWrite;
    logic                     ifIdFlush;
    logic                     idExWrite;
    logic                     idExFlush;
    logic                     exMemWrite;
    logic                     memWbBubble;
    logic                     memTimeout;
    logic [COUNTER_WIDTH-1:0] stallCycles;
    logic [COUNTER_WIDTH-1:0] flushCount;

    modport master (
        output idLHSRegisterIndex, idRHSRegisterIndex, idUsesLHS, idUsesRHS,
               exMemRead, exWriteRegisterIndex, exBranchTaken,
               memMemRead, memMemWrite, memReady,
        input  memRequest, pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush,
               exMemWrite, memWbBubble, memTimeout, stallCycles, flushCount
    );

    modport slave (
        input  idLHSRegisterIndex, idRHSRegisterIndex, idUsesLHS, idUsesRHS,
               exMemRead, exWriteRegisterIndex, exBranchTaken,
               memMemRead, memMemWrite, memReady,
        output memRequest, pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush,
               exMemWrite, memWbBubble, memTimeout, stallCycles, flushCount
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: load-use, taken-branch and data-memory wait hazards,
// plus a sticky memory timeout and saturating stall/flush counters.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT   = 16,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_hazard_controller_if.slave  bus
);
    localparam int WAIT_WIDTH = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_WIDTH-1:0]    WAIT_LIMIT = WAIT_WIDTH'(MEM_TIMEOUT);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX  = '1;

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t                  state, state_next;
    logic [WAIT_WIDTH-1:0]   wait_count, wait_next;
    logic                    mem_access, mem_stall, load_use, branch_flush;

    always_comb begin
        mem_access = bus.memMemRead | bus.memMemWrite;
        mem_stall  = mem_access & ~bus.memReady;
        load_use   = bus.exMemRead && (bus.exWriteRegisterIndex != 5'd0) &&
                     ((bus.idUsesLHS && bus.idLHSRegisterIndex == bus.exWriteRegisterIndex) ||
                      (bus.idUsesRHS && bus.idRHSRegisterIndex == bus.exWriteRegisterIndex));
        branch_flush = ~reset & ~mem_stall & bus.exBranchTaken;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            wait_count     <= '0;
            bus.memTimeout <= 1'b0;
        end else begin
            state      <= state_next;
            wait_count <= wait_next;
            if (wait_next == WAIT_LIMIT)
                bus.memTimeout <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        wait_next  = '0;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_WIDTH'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.memReady)
                    state_next = RUN;
                else if (wait_count == WAIT_LIMIT)
                    wait_next = WAIT_LIMIT;
                else
                    wait_next = wait_count + 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        bus.memRequest  = mem_access & (state == RUN) & ~reset;
        bus.pcWrite     = 1'b1;
        bus.ifIdWrite   = 1'b1;
        bus.idExWrite   = 1'b1;
        bus.exMemWrite  = 1'b1;
        bus.ifIdFlush   = 1'b0;
        bus.idExFlush   = 1'b0;
        bus.memWbBubble = 1'b0;
        if (reset) begin
            bus.pcWrite     = 1'b0;
            bus.ifIdWrite   = 1'b0;
            bus.idExWrite   = 1'b0;
            bus.exMemWrite  = 1'b0;
            bus.ifIdFlush   = 1'b1;
            bus.idExFlush   = 1'b1;
            bus.memWbBubble = 1'b1;
        end else if (mem_stall) begin
            // Whole front end freezes; pending branch/load-use is re-seen once memory completes.
            bus.pcWrite     = 1'b0;
            bus.ifIdWrite   = 1'b0;
            bus.idExWrite   = 1'b0;
            bus.exMemWrite  = 1'b0;
            bus.memWbBubble = 1'b1;
        end else if (bus.exBranchTaken) begin
            bus.ifIdFlush = 1'b1;
            bus.idExFlush = 1'b1;
        end else if (load_use) begin
            bus.pcWrite   = 1'b0;
            bus.ifIdWrite = 1'b0;
            bus.idExFlush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.stallCycles <= '0;
            bus.flushCount  <= '0;
        end else begin
            if (!bus.pcWrite && bus.stallCycles != COUNT_MAX)
                bus.stallCycles <= bus.stallCycles + 1'b1;
            if (branch_flush && bus.flushCount != COUNT_MAX)
                bus.flushCount <= bus.flushCount + 1'b1;
        end
    end
endmodule
